pipe_stage_reg: RTL

- Parametrised pipeline stage register with a ready/valid handshake. Successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a DATA_W-bit payload, typically concatenated IR/PC4/AO/DR fields, between two stages.
- A 2-entry skid buffer keeps full throughput while registering in_ready, so there is no combinational ready path across stages.
- Adds flush (bubble injection) and backpressure support, which the fixed-field stage registers do not have.

---
 rtl/pipe_stage_reg.sv | 59 +++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: ready/valid pipeline stage with a 2-entry skid buffer; PIPE_STAGE_BUBBLE_ZERO_EN zeroes bubbles
module pipe_stage_reg #(
  parameter int DATA_W = 128,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t state, next_state;
  logic [DATA_W-1:0] main_q, skid_q, main_src;
  logic accept, pop, load_main, load_skid;
  assign accept = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign out_valid = state != EMPTY;
  assign count = state;
  // next occupancy and which register takes new data
  always_comb begin
    next_state = flush ? EMPTY :
                 state == EMPTY ? (accept ? ONE : EMPTY) :
                 state == ONE ? (accept && !pop ? TWO : pop && !accept ? EMPTY : ONE) :
                 (pop ? ONE : TWO);
    load_main = (state == EMPTY && accept) || (state == ONE && accept && pop) || (state == TWO && pop);
    load_skid = state == ONE && accept && !pop;
    main_src = state == TWO ? skid_q : in_data;
  end
  // state, payload registers and the registered ready
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state    <= EMPTY;
      main_q   <= RESET_VAL;
      skid_q   <= RESET_VAL;
      in_ready <= 1'b1;
    end else begin
      state    <= next_state;
      in_ready <= next_state != TWO;
      if (flush) begin
        main_q <= RESET_VAL;
        skid_q <= RESET_VAL;
      end else begin
        if (load_main) main_q <= main_src;
        if (load_skid) skid_q <= in_data;
      end
    end
  end
`ifdef PIPE_STAGE_BUBBLE_ZERO_EN
  assign out_data = out_valid ? main_q : RESET_VAL;
`else
  assign out_data = main_q;
`endif
endmodule
